// File: rtl/laser_pkg.sv
// Shared types and constants for the laser-cutter host block.
// Point/centre coordinate types, host FSM states and the distance helper.
package laser_pkg;

    localparam int NPTS          = 40;
    localparam int RADIUS_SQ_DEF = 16;

    typedef logic [3:0] coord_t;

    typedef struct packed {
        coord_t c1x;
        coord_t c1y;
        coord_t c2x;
        coord_t c2y;
    } centre_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_DRAIN
    } host_state_e;

    // Squared distance with 8-bit unsigned squares and an 8-bit sum
    function automatic logic [7:0] dist_sq(
        input coord_t px,
        input coord_t py,
        input coord_t cx,
        input coord_t cy
    );
        logic [4:0] dx, dy, nx, ny;
        logic [3:0] ax, ay;
        logic [7:0] sx, sy;
        dx = {1'b0, px} - {1'b0, cx};
        dy = {1'b0, py} - {1'b0, cy};
        nx = -dx;
        ny = -dy;
        ax = dx[4] ? nx[3:0] : dx[3:0];
        ay = dy[4] ? ny[3:0] : dy[3:0];
        sx = {4'd0, ax} * {4'd0, ax};
        sy = {4'd0, ay} * {4'd0, ay};
        return sx + sy;
    endfunction

endpackage

// File: rtl/laser_cover_score.sv
// Sequential coverage scorer: one point per cycle over a captured set,
// counting points inside the radius of either centre.
module laser_cover_score
    import laser_pkg::*;
#(
    parameter int RADIUS_SQ = RADIUS_SQ_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_start,
    input  centre_t    i_c,
    output logic [5:0] o_idx,
    input  logic [7:0] i_pt,
    output logic       o_busy,
    output logic       o_valid,
    output logic [5:0] o_score
);

    localparam logic [5:0] IDX_LAST = 6'(NPTS - 1);
    localparam logic [7:0] RSQ      = 8'(RADIUS_SQ);

    logic       r_busy;
    logic       r_valid;
    logic [5:0] r_idx;
    logic [5:0] r_cnt;
    logic [5:0] r_score;
    logic [7:0] w_d1;
    logic [7:0] w_d2;
    logic       w_cov;
    logic [5:0] w_sum;

    // Point 0 is scored in the start cycle itself, so index and count restart here
    always_comb begin
        w_d1  = dist_sq(i_pt[7:4], i_pt[3:0], i_c.c1x, i_c.c1y);
        w_d2  = dist_sq(i_pt[7:4], i_pt[3:0], i_c.c2x, i_c.c2y);
        w_cov = (w_d1 <= RSQ) || (w_d2 <= RSQ);
        w_sum = (i_start ? 6'd0 : r_cnt) + {5'd0, w_cov};
    end

    assign o_idx   = i_start ? 6'd0 : r_idx;
    assign o_busy  = r_busy;
    assign o_valid = r_valid;
    assign o_score = r_score;

    // Walk the 40 points, accumulate, strobe the total after the last one
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_score <= '0;
        end else begin
            r_valid <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_idx  <= 6'd1;
                r_cnt  <= w_sum;
            end else if (r_busy) begin
                r_cnt <= w_sum;
                if (r_idx == IDX_LAST) begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                    r_score <= w_sum;
                end else begin
                    r_idx <= r_idx + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/laser_host.sv
// Host side of the laser point/centre interface: feeds point sets to the
// engine, collects centres. Optional scorer under LASER_HOST_SCORE_EN.
module laser_host
    import laser_pkg::*;
#(
    parameter int NUM_SETS  = 4,
    parameter int RADIUS_SQ = RADIUS_SQ_DEF,
    parameter int TIMEOUT   = 16384
) (
    input  logic                                              CLK,
    input  logic                                              RST,
    input  logic                                              LD_EN,
    input  logic [(NUM_SETS > 1 ? $clog2(NUM_SETS) : 1)-1:0] LD_SET,
    input  logic [5:0]                                        LD_IDX,
    input  logic [3:0]                                        LD_X,
    input  logic [3:0]                                        LD_Y,
    input  logic                                              START,
    output logic                                              BUSY,
    output logic                                              LRST,
    output logic [3:0]                                        X,
    output logic [3:0]                                        Y,
    input  logic [3:0]                                        C1X,
    input  logic [3:0]                                        C1Y,
    input  logic [3:0]                                        C2X,
    input  logic [3:0]                                        C2Y,
    input  logic                                              DONE,
    output logic                                              RES_VALID,
    output logic [(NUM_SETS > 1 ? $clog2(NUM_SETS) : 1)-1:0] RES_SET,
    output logic [15:0]                                       RES_C,
    output logic [5:0]                                        RES_SCORE,
    output logic                                              ERR,
    output logic                                              FINISH
);

    localparam int SW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [5:0]    IDX_LAST = 6'(NPTS - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(NUM_SETS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [7:0]    r_mem [NUM_SETS][NPTS];

    host_state_e   r_state;
    logic [SW-1:0] r_set;
    logic [5:0]    r_idx;
    logic [TW-1:0] r_tmo;
    logic          r_lrst;
    logic          r_busy;
    logic          r_err;
    logic          r_finish;

    logic          r_res_valid;
    logic [SW-1:0] r_res_set;
    centre_t       r_res_c;
    logic [5:0]    r_res_score;

    centre_t       w_centre;
    logic          w_cap;
    logic          w_sc_busy;
    logic [7:0]    w_feed_pt;
    logic          w_res_stb;
    logic [SW-1:0] w_res_set;
    centre_t       w_res_c;
    logic [5:0]    w_res_score;

    assign w_centre  = {C1X, C1Y, C2X, C2Y};
    assign w_cap     = (r_state == S_WAIT) && DONE;
    assign w_feed_pt = r_mem[r_set][r_idx];

    assign X         = (r_state == S_FEED) ? w_feed_pt[7:4] : 4'd0;
    assign Y         = (r_state == S_FEED) ? w_feed_pt[3:0] : 4'd0;
    assign LRST      = r_lrst;
    assign BUSY      = r_busy;
    assign ERR       = r_err;
    assign FINISH    = r_finish;
    assign RES_VALID = r_res_valid;
    assign RES_SET   = r_res_set;
    assign RES_C     = r_res_c;
    assign RES_SCORE = r_res_score;

    // Point memory: loader writes only while idle, out-of-range index dropped
    always_ff @(posedge CLK) begin
        if (LD_EN && !r_busy && (LD_IDX < 6'(NPTS)))
            r_mem[LD_SET][LD_IDX] <= {LD_X, LD_Y};
    end

`ifdef LASER_HOST_SCORE_EN
    logic          r_sc_start;
    logic [SW-1:0] r_cap_set;
    centre_t       r_cap_c;
    logic [5:0]    w_sc_idx;
    logic          w_sc_busy_core;
    logic          w_sc_valid;
    logic [5:0]    w_sc_score;

    // Hold the captured centres/set for the scorer; kick it one cycle later
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sc_start <= 1'b0;
            r_cap_set  <= '0;
            r_cap_c    <= '0;
        end else begin
            r_sc_start <= w_cap;
            if (w_cap) begin
                r_cap_set <= r_set;
                r_cap_c   <= w_centre;
            end
        end
    end

    laser_cover_score #(
        .RADIUS_SQ (RADIUS_SQ)
    ) u_score (
        .CLK     (CLK),
        .RST     (RST),
        .i_start (r_sc_start),
        .i_c     (r_cap_c),
        .o_idx   (w_sc_idx),
        .i_pt    (r_mem[r_cap_set][w_sc_idx]),
        .o_busy  (w_sc_busy_core),
        .o_valid (w_sc_valid),
        .o_score (w_sc_score)
    );

    assign w_sc_busy = w_sc_busy_core | r_sc_start;

    // Result comes from the scorer once the whole set is counted
    always_comb begin
        w_res_stb   = w_sc_valid;
        w_res_set   = r_cap_set;
        w_res_c     = r_cap_c;
        w_res_score = w_sc_score;
    end
`else
    assign w_sc_busy = 1'b0;

    // Without a scorer the result is the raw capture, zero score
    always_comb begin
        w_res_stb   = w_cap;
        w_res_set   = r_set;
        w_res_c     = w_centre;
        w_res_score = 6'd0;
    end
`endif

    // Result register: one-cycle strobe, payload held until the next one
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_res_valid <= 1'b0;
            r_res_set   <= '0;
            r_res_c     <= '0;
            r_res_score <= '0;
        end else begin
            r_res_valid <= w_res_stb;
            if (w_res_stb) begin
                r_res_set   <= w_res_set;
                r_res_c     <= w_res_c;
                r_res_score <= w_res_score;
            end
        end
    end

    // Run sequencer: feed 40 points, wait for DONE, repeat per set
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_set    <= '0;
            r_idx    <= '0;
            r_tmo    <= '0;
            r_lrst   <= 1'b1;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_lrst <= 1'b1;
                    if (START) begin
                        r_state <= S_FEED;
                        r_lrst  <= 1'b0;
                        r_set   <= '0;
                        r_idx   <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (DONE)
                        r_err <= 1'b1;
                    if (r_idx == IDX_LAST) begin
                        r_idx   <= '0;
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                S_WAIT: begin
                    if (DONE) begin
                        if (w_sc_busy)
                            r_err <= 1'b1;
                        if (r_set == SET_LAST) begin
                            r_lrst  <= 1'b1;
                            r_state <= S_DRAIN;
                        end else begin
                            r_set   <= r_set + SW'(1);
                            r_idx   <= '0;
                            r_state <= S_FEED;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_err    <= 1'b1;
                        r_lrst   <= 1'b1;
                        r_finish <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!w_sc_busy) begin
                        r_finish <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
